uart_rx_fifo: RTL and testbench

Receive buffer directly downstream of the UART receiver in the APB UART peripheral. Captures each completed character (data plus parity/framing status) on the receiver's completion strobe and queues it in a first-word-fall-through FIFO. The APB register logic drains the queue. Provides level, overrun, and threshold-interrupt status for the register map.

---
 rtl/uart_pkg.sv | 11 +
 rtl/uart_fifo_mem.sv | 27 ++
 rtl/uart_rx_fifo.sv | 117 +++++++++++
 tb/tb_uart_rx_fifo.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Constants shared by the UART receive path and the APB register block.
// The entry layout places the data in the low bits, with the status bits above it.
package uart_pkg;

  localparam int UART_DATA_W  = 8;
  localparam int RXE_DATA_LSB = 0;
  localparam int RXE_PAR_BIT  = 8;
  localparam int RXE_FRM_BIT  = 9;
  localparam int RXE_W        = 10;

endpackage

// File: rtl/uart_fifo_mem.sv
// Storage array for the RX FIFO.
// It has a synchronous write port and an asynchronous read port, and it is not reset.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = RXE_W
) (
  input  logic                     clk,
  input  logic                     i_wr_en,
  input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
  input  logic [W-1:0]             i_wr_data,
  input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
  output logic [W-1:0]             o_rd_data
);

  logic [W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive buffer that sits behind the UART receiver.
// It edge-detects the completion strobe and reports level, overrun and threshold interrupt status.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int  DATA_W = UART_DATA_W,
  parameter int  DEPTH  = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_done,
  input  logic              parity_error,
  input  logic              framing_error,
  input  logic              rd_en,
  input  logic              flush,
  input  logic              clr_overrun,
  input  logic [ADDR_W:0]   threshold,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_parity_err,
  output logic              rd_framing_err,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   level,
  output logic              overrun,
  output logic              irq
);

  localparam int              EW       = DATA_W + 2;
  localparam logic [ADDR_W:0] LVL_FULL = (ADDR_W + 1)'(DEPTH);

  logic              r_rx_done_q;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_level;
  logic              r_overrun;

  logic          w_wr;
  logic          w_rd;
  logic          w_push;
  logic          w_pop;
  logic          w_drop;
  logic          w_empty;
  logic          w_full;
  logic [EW-1:0] w_wr_entry;
  logic [EW-1:0] w_head;

  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == LVL_FULL);

  assign w_wr   = rx_done & ~r_rx_done_q;
  assign w_rd   = rd_en & ~w_empty;
  // On a full FIFO, a same-cycle pop frees the head slot, and that slot is where wr_ptr points.
  assign w_push = w_wr & (~w_full | w_rd) & ~flush & ~reset;
  assign w_pop  = w_rd & ~flush;
  assign w_drop = w_wr & w_full & ~w_rd & ~flush;

  assign w_wr_entry = {framing_error, parity_error, rx_data};

  uart_fifo_mem #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_mem (
    .clk       (clk),
    .i_wr_en   (w_push),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (w_wr_entry),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_head)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_done_q <= 1'b0;
    end else begin
      r_rx_done_q <= rx_done;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // A dropped character outranks a same-cycle clear, so the loss is never missed.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end else if (clr_overrun) begin
      r_overrun <= 1'b0;
    end
  end

  assign rd_data        = w_head[DATA_W-1:0];
  assign rd_parity_err  = w_head[DATA_W];
  assign rd_framing_err = w_head[DATA_W+1];
  assign empty          = w_empty;
  assign full           = w_full;
  assign level          = r_level;
  assign overrun        = r_overrun;
  assign irq            = r_overrun | ((threshold != '0) & (r_level >= threshold));

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: a queue-based reference model is updated at each clock edge,
// and a negedge monitor compares every status output and the FWFT head against it.
module tb_uart_rx_fifo;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
  localparam int AW     = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [DATA_W-1:0] rx_data;
  logic          rx_done;
  logic          parity_error;
  logic          framing_error;
  logic          rd_en;
  logic          flush;
  logic          clr_overrun;
  logic [AW:0]   threshold;
  logic [DATA_W-1:0] rd_data;
  logic          rd_parity_err;
  logic          rd_framing_err;
  logic          empty;
  logic          full;
  logic [AW:0]   level;
  logic          overrun;
  logic          irq;

  always #5 clk = ~clk;

  uart_rx_fifo dut (
    .clk            (clk),
    .reset          (reset),
    .rx_data        (rx_data),
    .rx_done        (rx_done),
    .parity_error   (parity_error),
    .framing_error  (framing_error),
    .rd_en          (rd_en),
    .flush          (flush),
    .clr_overrun    (clr_overrun),
    .threshold      (threshold),
    .rd_data        (rd_data),
    .rd_parity_err  (rd_parity_err),
    .rd_framing_err (rd_framing_err),
    .empty          (empty),
    .full           (full),
    .level          (level),
    .overrun        (overrun),
    .irq            (irq)
  );

  int n_vec  = 0;
  int n_miss = 0;
  bit chk_en = 1'b0;

  // Reference model: the FIFO contents are an ordered queue of {frm, par, data} entries.
  logic [9:0] mq[$];
  bit         m_prev = 1'b0;
  bit         m_ovr  = 1'b0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin : model
    bit wr;
    bit set;
    if (reset) begin
      mq.delete();
      m_prev = 1'b0;
      m_ovr  = 1'b0;
    end else begin
      wr     = rx_done && !m_prev;
      m_prev = rx_done;
      set    = 1'b0;
      if (flush) begin
        mq.delete();
      end else begin
        if (rd_en && mq.size() > 0) void'(mq.pop_front());
        if (wr) begin
          if (mq.size() < DEPTH) mq.push_back({framing_error, parity_error, rx_data});
          else set = 1'b1;
        end
      end
      if (set) m_ovr = 1'b1;
      else if (clr_overrun) m_ovr = 1'b0;
    end
  end

  always @(negedge clk) begin : monitor
    int n;
    if (chk_en) begin
      n = mq.size();
      cmp("level", 32'(level), 32'(n));
      cmp("empty", 32'(empty), 32'(n == 0));
      cmp("full", 32'(full), 32'(n == DEPTH));
      cmp("overrun", 32'(overrun), 32'(m_ovr));
      cmp("irq", 32'(irq), 32'(m_ovr || (threshold != 0 && n >= int'(threshold))));
      if (n > 0) begin
        cmp("rd_data", 32'(rd_data), 32'(mq[0][7:0]));
        cmp("rd_parity_err", 32'(rd_parity_err), 32'(mq[0][8]));
        cmp("rd_framing_err", 32'(rd_framing_err), 32'(mq[0][9]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d, input logic p, input logic f);
    rx_data = d; parity_error = p; framing_error = f; rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    tick();
  endtask

  task automatic pop();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  initial begin
    int rd_pct;
    reset = 1'b1; rx_data = '0; rx_done = 1'b0; parity_error = 1'b0; framing_error = 1'b0;
    rd_en = 1'b0; flush = 1'b0; clr_overrun = 1'b0; threshold = '0;
    tick();
    chk_en = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    at_neg();
    cmp("rst_empty", 32'(empty), 1); cmp("rst_level", 32'(level), 0);
    cmp("rst_full", 32'(full), 0); cmp("rst_irq", 32'(irq), 0); cmp("rst_overrun", 32'(overrun), 0);

    send(8'hA5, 1'b0, 1'b0);
    at_neg();
    cmp("single_level", 32'(level), 1); cmp("single_data", 32'(rd_data), 32'hA5);
    pop();
    at_neg();
    cmp("single_popped_empty", 32'(empty), 1);

    rx_data = 8'h3C; parity_error = 1'b1; framing_error = 1'b0; rx_done = 1'b1;
    tick(); tick(); tick();
    rx_done = 1'b0; parity_error = 1'b0;
    tick();
    at_neg();
    cmp("stretch_level", 32'(level), 1); cmp("stretch_par", 32'(rd_parity_err), 1);
    cmp("stretch_frm", 32'(rd_framing_err), 0);
    pop();

    for (int i = 1; i <= 8; i++) send(8'(i), 1'b0, 1'b0);
    at_neg();
    cmp("fill_full", 32'(full), 1);
    send(8'h09, 1'b0, 1'b0);
    at_neg();
    cmp("ovr_flag", 32'(overrun), 1); cmp("ovr_irq", 32'(irq), 1);
    cmp("ovr_level", 32'(level), 8); cmp("ovr_head", 32'(rd_data), 1);
    for (int i = 1; i <= 8; i++) begin
      at_neg();
      cmp("drain_order", 32'(rd_data), 32'(i));
      tick();
      pop();
    end
    at_neg();
    cmp("drain_empty", 32'(empty), 1);
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    at_neg();
    cmp("clr_overrun", 32'(overrun), 0);

    for (int i = 1; i <= 8; i++) send(8'(i), 1'b0, 1'b0);
    rx_data = 8'h55; rx_done = 1'b1; rd_en = 1'b1;
    tick();
    rx_done = 1'b0; rd_en = 1'b0;
    tick();
    at_neg();
    cmp("wrpop_overrun", 32'(overrun), 0); cmp("wrpop_level", 32'(level), 8);
    cmp("wrpop_head", 32'(rd_data), 2);
    flush = 1'b1;
    tick();
    flush = 1'b0;

    for (int i = 0; i < 20; i++) begin
      rx_data = 8'(100 + i); rx_done = 1'b1;
      tick();
      rx_done = 1'b0;
      at_neg();
      cmp("wrap_data", 32'(rd_data), 32'(100 + i));
      cmp("wrap_level", 32'(level), 1);
      tick();
      pop();
    end

    threshold = 4'd3;
    send(8'h11, 1'b0, 1'b0); send(8'h22, 1'b0, 1'b1);
    at_neg();
    cmp("thr_irq_2", 32'(irq), 0);
    send(8'h33, 1'b1, 1'b1);
    at_neg();
    cmp("thr_irq_3", 32'(irq), 1);
    rx_data = 8'h44; rx_done = 1'b1; flush = 1'b1;
    tick();
    rx_done = 1'b0; flush = 1'b0;
    at_neg();
    cmp("flush_level", 32'(level), 0); cmp("flush_empty", 32'(empty), 1);
    cmp("flush_irq", 32'(irq), 0); cmp("flush_overrun", 32'(overrun), 0);
    tick();
    pop();
    at_neg();
    cmp("empty_rd_level", 32'(level), 0);
    tick();

    rd_pct = 40;
    for (int i = 0; i < 4000; i++) begin
      if (i % 200 == 0) rd_pct = (i / 200) % 3 == 0 ? 10 : ((i / 200) % 3 == 1 ? 45 : 85);
      if (i % 150 == 0) threshold = 4'($urandom_range(0, 8));
      rx_data       = 8'($urandom);
      parity_error  = 1'($urandom_range(0, 1));
      framing_error = 1'($urandom_range(0, 1));
      rx_done       = ($urandom_range(0, 2) == 0);
      rd_en         = ($urandom_range(0, 99) < rd_pct);
      flush         = ($urandom_range(0, 99) == 0);
      clr_overrun   = ($urandom_range(0, 39) == 0);
      reset         = ($urandom_range(0, 599) == 0);
      tick();
    end
    rx_done = 1'b0; rd_en = 1'b0; flush = 1'b0; clr_overrun = 1'b0; reset = 1'b0;
    tick();
    at_neg();
    chk_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
